// File: rtl/cpu_fsm_pkg.sv
// Shared types and encodings for the simple RISC CPU controller.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_WRITE
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op field meaning depends on opcode
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;
  localparam logic [1:0] VSEL_MDATA = 2'b10;
  localparam logic [1:0] VSEL_PC    = 2'b11;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;
    logic [15:0] sximm8;
    logic        legal;
  } dec_t;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/cpu_fsm_if.sv
// Controller bus: wrapper-side inputs plus all datapath control outputs.
interface cpu_fsm_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              load;
  logic              start;
  logic [DATA_W-1:0] instr;
  logic              waiting;
  logic [REG_AW-1:0] readnum;
  logic [REG_AW-1:0] writenum;
  logic              write;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              asel;
  logic              bsel;
  logic [1:0]        vsel;
  logic [1:0]        shift;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] sximm8;
  logic              illegal;

  modport master (
    output load, start, instr,
    input  waiting, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, alu_op, sximm8, illegal
  );

  modport slave (
    input  load, start, instr,
    output waiting, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, alu_op, sximm8, illegal
  );
endinterface

// File: rtl/cpu_fsm_instr_decoder.sv
// Combinational field extraction and legality check for the instruction register.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] i_ir,
  output dec_t        o_dec
);

  logic [2:0] w_opcode;
  logic [1:0] w_op;

  assign w_opcode = i_ir[15:13];
  assign w_op     = i_ir[12:11];

  always_comb begin
    o_dec        = '0;
    o_dec.opcode = w_opcode;
    o_dec.op     = w_op;
    o_dec.rn     = i_ir[10:8];
    o_dec.rd     = i_ir[7:5];
    o_dec.sh     = i_ir[4:3];
    o_dec.rm     = i_ir[2:0];
    o_dec.sximm8 = sext8(i_ir[7:0]);
    // MOV only has immediate and register forms; every ALU op is supported
    o_dec.legal  = (w_opcode == OPC_ALU) ||
                   ((w_opcode == OPC_MOV) && ((w_op == OP_MOV_IMM) || (w_op == OP_MOV_REG)));
  end

endmodule

// File: rtl/cpu_fsm.sv
// Instruction register and Moore control FSM: one instruction per start.
module cpu_fsm
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  cpu_fsm_if.slave bus
);

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_ir;
  logic              r_illegal;
  dec_t              w_dec;

  logic [REG_AW-1:0] w_readnum, w_writenum;
  logic              w_write, w_loada, w_loadb, w_loadc, w_loads, w_asel;
  logic [1:0]        w_vsel, w_shift, w_alu_op;
  logic              w_is_cmp;

  instr_decoder u_dec (
    .i_ir  (r_ir),
    .o_dec (w_dec)
  );

  assign w_is_cmp = (w_dec.opcode == OPC_ALU) && (w_dec.op == OP_CMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_WAIT;
    else        r_state <= w_next;
  end

  // IR captures on the start edge too, so DECODE sees the fresh word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir      <= '0;
      r_illegal <= 1'b0;
    end else begin
      if ((r_state == S_WAIT) && bus.load) r_ir <= bus.instr;
      if ((r_state == S_WAIT) && bus.start)
        r_illegal <= 1'b0;
      else if ((r_state == S_DECODE) && !w_dec.legal)
        r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_readnum  = '0;
    w_writenum = '0;
    w_write    = 1'b0;
    w_loada    = 1'b0;
    w_loadb    = 1'b0;
    w_loadc    = 1'b0;
    w_loads    = 1'b0;
    w_asel     = 1'b0;
    w_vsel     = VSEL_C;
    w_shift    = 2'b00;
    w_alu_op   = ALU_ADD;
    case (r_state)
      S_WAIT: if (bus.start) w_next = S_DECODE;
      S_DECODE: begin
        if (!w_dec.legal)
          w_next = S_WAIT;
        else if (w_dec.opcode == OPC_MOV)
          w_next = (w_dec.op == OP_MOV_IMM) ? S_WRITE_IMM : S_LOAD_B;
        else
          w_next = (w_dec.op == OP_MVN) ? S_LOAD_B : S_LOAD_A;
      end
      S_WRITE_IMM: begin
        w_write    = 1'b1;
        w_writenum = w_dec.rn;
        w_vsel     = VSEL_IMM;
        w_next     = S_WAIT;
      end
      S_LOAD_A: begin
        w_readnum = w_dec.rn;
        w_loada   = 1'b1;
        w_next    = S_LOAD_B;
      end
      S_LOAD_B: begin
        w_readnum = w_dec.rm;
        w_loadb   = 1'b1;
        w_next    = S_EXEC;
      end
      S_EXEC: begin
        w_shift = w_dec.sh;
        // MOV Rd,Rm is computed as 0 + shifted Rm
        if (w_dec.opcode == OPC_MOV) begin
          w_asel  = 1'b1;
          w_loadc = 1'b1;
        end else begin
          case (w_dec.op)
            OP_CMP:  begin w_alu_op = ALU_SUB;  w_loads = 1'b1; end
            OP_AND:  begin w_alu_op = ALU_AND;  w_loadc = 1'b1; end
            OP_MVN:  begin w_alu_op = ALU_NOTB; w_loadc = 1'b1; end
            default: begin w_alu_op = ALU_ADD;  w_loadc = 1'b1; end
          endcase
        end
        w_next = w_is_cmp ? S_WAIT : S_WRITE;
      end
      S_WRITE: begin
        w_write    = 1'b1;
        w_writenum = w_dec.rd;
        w_vsel     = VSEL_C;
        w_next     = S_WAIT;
      end
      default: w_next = S_WAIT;
    endcase
  end

  assign bus.waiting  = (r_state == S_WAIT);
  assign bus.readnum  = w_readnum;
  assign bus.writenum = w_writenum;
  assign bus.write    = w_write;
  assign bus.loada    = w_loada;
  assign bus.loadb    = w_loadb;
  assign bus.loadc    = w_loadc;
  assign bus.loads    = w_loads;
  assign bus.asel     = w_asel;
  assign bus.bsel     = 1'b0;
  assign bus.vsel     = w_vsel;
  assign bus.shift    = w_shift;
  assign bus.alu_op   = w_alu_op;
  assign bus.sximm8   = w_dec.sximm8;
  assign bus.illegal  = r_illegal;

endmodule

// File: doc/cpu_fsm.md
Name: cpu_fsm

Overview:
Instruction register, decoder and control state machine for the 16-bit simple RISC CPU. It captures an instruction, decodes it, and drives the register-file, A/B/C load, mux-select, shift and ALU controls of the datapath. It sequences one instruction per `start` and reports `waiting` when idle. It sits between the top-level `cpu` wrapper inputs (`instr`, `load`, `start`) and the datapath.

Parameters:
DATA_W, 16, datapath width; only 16 is supported.
REG_AW, 3, register-number width (8 registers).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
load  input  1  capture `instr` into the IR
start  input  1  begin executing the IR
instr  input  16  instruction word
waiting  output  1  1 in WAIT state
readnum  output  3  register-file read address
writenum  output  3  register-file write address
write  output  1  register-file write enable
loada  output  1  A register load
loadb  output  1  B register load
loadc  output  1  C register load
loads  output  1  status (N,V,Z) load
asel  output  1  1: ALU A input forced to 0
bsel  output  1  1: ALU B input from sximm5 (held 0 this lab)
vsel  output  2  write-back source: 00 C, 01 sximm8, 10 mdata, 11 PC
shift  output  2  shifter control (IR[4:3]) during EXEC
alu_op  output  2  00 ADD, 01 SUB, 10 AND, 11 NOT B
sximm8  output  16  sign-extended IR[7:0]
illegal  output  1  last decoded opcode unsupported

Behaviour:
- Instruction fields:
  - opcode = IR[15:13]; op = IR[12:11]; Rn = IR[10:8]; Rd = IR[7:5]; sh = IR[4:3]; Rm = IR[2:0].
- IR load:
  - IR loads `instr` on a clk edge only when load=1 and state=WAIT.
  - `load` while busy is ignored.
- Reset:
  - Async reset puts the FSM in WAIT and clears the IR to 0 and `illegal` to 0.
  - All load/write strobes are 0 while reset is asserted and in WAIT.
- Output style:
  - Moore outputs; every strobe is asserted for exactly the one cycle its state is held.
- Start:
  - WAIT -> DECODE on an edge with start=1.
  - `start` in any other state is ignored.
  - `start` and `load` on the same edge: the IR captures first, and DECODE sees the new IR.
- DECODE transitions:
  - opcode 110, op 10 -> WRITE_IMM.
  - opcode 110, op 00 -> LOAD_B.
  - opcode 101, op 00/01/10 -> LOAD_A.
  - opcode 101, op 11 -> LOAD_B.
  - Anything else -> WAIT with `illegal`=1.
- `illegal` is cleared on the next start.
- States:
  - WRITE_IMM: write=1, writenum=Rn, vsel=01 -> WAIT.
  - LOAD_A: readnum=Rn, loada=1 -> LOAD_B.
  - LOAD_B: readnum=Rm, loadb=1 -> EXEC.
  - EXEC: shift=sh.
    - MOV: asel=1, alu_op=00, loadc=1.
    - ADD/AND: alu_op=00/10, loadc=1.
    - MVN: alu_op=11, loadc=1.
    - CMP: alu_op=01, loads=1, loadc=0.
    - CMP -> WAIT; others -> WRITE.
  - WRITE: write=1, writenum=Rd, vsel=00 -> WAIT.
- Latency in edges from the start edge until waiting=1:
  - MOV imm: 3.
  - CMP: 5.
  - MOV reg: 5.
  - MVN: 5.
  - ADD/AND: 6.
  - Illegal: 2.
- Defaults: in states where a field is unused, readnum/writenum=0, shift=00, alu_op=00, asel=bsel=0.
- Flags: only CMP updates status; no other instruction asserts `loads`.
- Sign extension: sximm8 = {{8{IR[7]}}, IR[7:0]}, combinational from the IR.
- Reset mid-instruction: immediately returns to WAIT; any strobe in flight is dropped.

Decomposition:
- Package `cpu_pkg`:
  - state_t enum (WAIT, DECODE, WRITE_IMM, LOAD_A, LOAD_B, EXEC, WRITE).
  - Opcode constants OPC_MOV=3'b110, OPC_ALU=3'b101.
  - ALU op constants.
  - vsel constants.
- Sub-module `instr_decoder`: combinational. IR -> opcode, op, Rn, Rd, Rm, sh, sximm8, legal.
- The FSM, IR register and output logic live in `cpu_fsm`.

Test Plan:
- Reset with rst_n=0 mid-cycle -> waiting=1 and write/loada/loadb/loadc/loads=0, even without a clock edge.
- load+start with 0xD180 (MOV R1,#-128) -> DECODE, then WRITE_IMM with write=1, writenum=1, vsel=01, sximm8=0xFF80; waiting=1 after the 3rd edge.
- 0xC046 (MOV R2,R6) -> LOAD_B readnum=6, EXEC asel=1 loadc=1, WRITE writenum=2 vsel=00; waiting=0 at edge 3 and 1 after edge 5.
- 0xA2E6 (ADD R7,R2,R6) -> LOAD_A readnum=2, LOAD_B readnum=6, EXEC alu_op=00, WRITE writenum=7; waiting=1 after 6 edges.
- 0xAB05 (CMP R3,R5) -> loads=1 for exactly one cycle with alu_op=01; write never asserted; waiting=1 after 5 edges.
- 0xE000 (illegal) -> illegal=1 and waiting=1 after 2 edges with no strobes. Then start ADD and assert rst_n=0 in EXEC -> WAIT immediately, loadc never completes, illegal=0.
